// File: rtl/clmul_kara_split_seq_pkg.sv
// Shared constants, FSM state type and helpers for the Karatsuba split stage
// of the 64-bit carry-less multiplier.
package kara_pkg;

    localparam int HALF_W = 32;
    localparam int DIGIT  = 4;
    localparam int PROD_W = 2 * HALF_W - 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MUL_LO  = 3'd1,
        MUL_HI  = 3'd2,
        MUL_MID = 3'd3,
        DONE    = 3'd4
    } kara_state_t;

    // Number of digit-serial steps needed for one W x W partial product.
    function automatic int digit_count(input int w, input int d);
        return w / d;
    endfunction

endpackage

// File: rtl/clmul_kara_split_seq_if.sv
// Operand/result handshake bundle between the producer, the split stage and
// the downstream overlap-sum recombiner.
interface clmul_kara_split_seq_if
    import kara_pkg::*;
#(
    parameter int W = HALF_W
);
    logic             in_valid;
    logic             in_ready;
    logic [2*W-1:0]   a;
    logic [2*W-1:0]   b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-2:0]   z0;
    logic [2*W-2:0]   z1;
    logic [2*W-2:0]   z2;
    logic             busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, z0, z1, z2, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, z0, z1, z2, busy
    );
endinterface

// File: rtl/clmul_kara_split_seq_gf2_digit_mac.sv
// One digit-serial step of a GF(2)[x] multiply: shift the running product by
// one digit and fold in x times the current D-bit digit of y.
module gf2_digit_mac #(
    parameter int W = 32,
    parameter int D = 4
) (
    input  logic [2*W-2:0] acc_in,
    input  logic [W-1:0]   x,
    input  logic [D-1:0]   digit,
    output logic [2*W-2:0] acc_out
);
    localparam int PW = 2 * W - 1;

    logic [PW-1:0] partial_s;

    // Carry-less partial sum of x shifted by each set digit bit.
    always_comb begin
        partial_s = '0;
        for (int j = 0; j < D; j++) begin
            partial_s = partial_s ^ (digit[j] ? (PW'(x) << j) : {PW{1'b0}});
        end
    end

    // Bits pushed past the top can only be zero: the final degree is at most 2W-2.
    assign acc_out = (acc_in << D) ^ partial_s;

endmodule

// File: rtl/clmul_kara_split_seq.sv
// Karatsuba split stage: one digit-serial GF(2) engine computes z0, z2 and z1
// in three consecutive phases, then offers the bundle over valid/ready.
module clmul_kara_split_seq
    import kara_pkg::*;
#(
    parameter int W = HALF_W,
    parameter int D = DIGIT
) (
    input logic                   clk,
    input logic                   rst_n,
    clmul_kara_split_seq_if.slave bus
);
    localparam int PW   = 2 * W - 1;
    localparam int NDIG = digit_count(W, D);
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int BW   = $clog2(W);

    kara_state_t    state_r;
    kara_state_t    next_state_s;
    logic [2*W-1:0] a_r;
    logic [2*W-1:0] b_r;
    logic [PW-1:0]  acc_r;
    logic [CW-1:0]  cnt_r;
    logic [PW-1:0]  z0_r;
    logic [PW-1:0]  z1_r;
    logic [PW-1:0]  z2_r;
    logic           in_ready_r;
    logic           out_valid_r;
    logic           busy_r;

    logic           accept_s;
    logic           last_s;
    logic           mul_s;
    logic [W-1:0]   x_s;
    logic [W-1:0]   y_s;
    logic [BW-1:0]  base_s;
    logic [D-1:0]   digit_s;
    logic [PW-1:0]  acc_next_s;

    assign accept_s = (state_r == IDLE) && bus.in_valid;
    assign last_s   = (cnt_r == CW'(NDIG - 1));

    // Next-state decode for the phase sequencer.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE:    if (accept_s)      next_state_s = MUL_LO;  else next_state_s = IDLE;
            MUL_LO:  if (last_s)        next_state_s = MUL_HI;  else next_state_s = MUL_LO;
            MUL_HI:  if (last_s)        next_state_s = MUL_MID; else next_state_s = MUL_HI;
            MUL_MID: if (last_s)        next_state_s = DONE;    else next_state_s = MUL_MID;
            DONE:    if (bus.out_ready) next_state_s = IDLE;    else next_state_s = DONE;
            default: next_state_s = IDLE;
        endcase
    end

    // Per-phase operand selection for the shared MAC engine.
    always_comb begin
        x_s   = '0;
        y_s   = '0;
        mul_s = 1'b0;
        case (state_r)
            MUL_LO: begin
                x_s   = a_r[W-1:0];
                y_s   = b_r[W-1:0];
                mul_s = 1'b1;
            end
            MUL_HI: begin
                x_s   = a_r[2*W-1:W];
                y_s   = b_r[2*W-1:W];
                mul_s = 1'b1;
            end
            MUL_MID: begin
                x_s   = a_r[W-1:0] ^ a_r[2*W-1:W];
                y_s   = b_r[W-1:0] ^ b_r[2*W-1:W];
                mul_s = 1'b1;
            end
            default: begin
                x_s   = '0;
                y_s   = '0;
                mul_s = 1'b0;
            end
        endcase
    end

    // y is walked MSB digit first so the accumulator only ever shifts left.
    assign base_s  = BW'((NDIG - 1 - int'(cnt_r)) * D);
    assign digit_s = y_s[base_s +: D];

    gf2_digit_mac #(
        .W (W),
        .D (D)
    ) u_mac (
        .acc_in  (acc_r),
        .x       (x_s),
        .digit   (digit_s),
        .acc_out (acc_next_s)
    );

    // Phase sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Operand capture, digit accumulation, result registers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r         <= '0;
            b_r         <= '0;
            acc_r       <= '0;
            cnt_r       <= '0;
            z0_r        <= '0;
            z1_r        <= '0;
            z2_r        <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            in_ready_r  <= (next_state_s == IDLE);
            out_valid_r <= (next_state_s == DONE);
            busy_r      <= (next_state_s != IDLE);
            if (accept_s) begin
                a_r   <= bus.a;
                b_r   <= bus.b;
                acc_r <= '0;
                cnt_r <= '0;
            end else if (mul_s) begin
                if (last_s) begin
                    acc_r <= '0;
                    cnt_r <= '0;
                    case (state_r)
                        MUL_LO:  z0_r <= acc_next_s;
                        MUL_HI:  z2_r <= acc_next_s;
                        MUL_MID: z1_r <= acc_next_s;
                        default: z0_r <= z0_r;
                    endcase
                end else begin
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_r + CW'(1);
                end
            end else begin
                acc_r <= acc_r;
                cnt_r <= cnt_r;
            end
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.busy      = busy_r;
    assign bus.z0        = z0_r;
    assign bus.z1        = z1_r;
    assign bus.z2        = z2_r;

endmodule

// File: tb/tb_clmul_kara_split_seq.sv
// Scoreboard bench for clmul_kara_split_seq: directed vectors, stall, reset
// abort and random back-to-back traffic against a bitwise carry-less model.
module tb_clmul_kara_split_seq;

    typedef struct packed {
        logic [62:0] z0;
        logic [62:0] z1;
        logic [62:0] z2;
    } bundle_t;

    logic    clk   = 1'b0;
    logic    rst_n = 1'b1;
    bundle_t exp_q[$];
    int      n_tests  = 0;
    int      n_fail   = 0;
    int      n_out    = 0;
    int      n_pushed = 0;
    int      cyc      = 0;
    int      acc_cyc  = -1000;
    int      rdy_mode = 0;
    logic    ov_prev  = 1'b0;

    always #5 clk = ~clk;

    clmul_kara_split_seq_if #(.W(32)) dut_if ();

    clmul_kara_split_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: 0 = always ready, 1 = random, 2 = stalled.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       dut_if.out_ready = 1'b1;
            1:       dut_if.out_ready = 1'($urandom_range(0, 1));
            default: dut_if.out_ready = 1'b0;
        endcase
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [62:0] clmul(input logic [31:0] x, input logic [31:0] y);
        logic [62:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            if (y[i]) r = r ^ ({31'd0, x} << i);
        end
        return r;
    endfunction

    function automatic bundle_t golden(input logic [63:0] a, input logic [63:0] b);
        bundle_t g;
        g.z0 = clmul(a[31:0], b[31:0]);
        g.z2 = clmul(a[63:32], b[63:32]);
        g.z1 = clmul(a[31:0] ^ a[63:32], b[31:0] ^ b[63:32]);
        return g;
    endfunction

    // Monitor: latency on each rising out_valid, bundle compare on each handshake.
    always @(negedge clk) begin
        bundle_t e;
        if (dut_if.out_valid === 1'b1 && ov_prev !== 1'b1)
            chk("latency", 64'(cyc - acc_cyc), 64'd24);
        ov_prev <= dut_if.out_valid;
        if (dut_if.out_valid === 1'b1 && dut_if.out_ready === 1'b1) begin
            n_out <= n_out + 1;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("z0", {1'b0, dut_if.z0}, {1'b0, e.z0});
                chk("z1", {1'b0, dut_if.z1}, {1'b0, e.z1});
                chk("z2", {1'b0, dut_if.z2}, {1'b0, e.z2});
            end
        end
    end

    // Issue one operand pair; called and returns #1 after a rising edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input bit push, input bundle_t e);
        int w;
        w = 0;
        dut_if.a        = a;
        dut_if.b        = b;
        dut_if.in_valid = 1'b1;
        while (dut_if.in_ready !== 1'b1 && w < 300) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 300) begin
            chk("accept_timeout", 64'd1, 64'd0);
            dut_if.in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            acc_cyc         = cyc;
            dut_if.in_valid = 1'b0;
            if (push) begin
                exp_q.push_back(e);
                n_pushed++;
            end
        end
    endtask

    initial begin
        bundle_t e;
        logic [63:0] ra, rb;
        int w;
        dut_if.in_valid = 1'b0;
        dut_if.a        = '0;
        dut_if.b        = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, dut_if.in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, dut_if.out_valid}, 64'd0);
        chk("rst_busy", {63'd0, dut_if.busy}, 64'd0);
        chk("rst_z0", {1'b0, dut_if.z0}, 64'd0);
        chk("rst_z1", {1'b0, dut_if.z1}, 64'd0);
        chk("rst_z2", {1'b0, dut_if.z2}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Hand-computed directed vectors.
        e = '{z0: 63'd1, z1: 63'd1, z2: 63'd0};
        send(64'h0000_0000_0000_0001, 64'h0000_0000_0000_0001, 1'b1, e);
        chk("busy_in_op", {63'd0, dut_if.busy}, 64'd1);
        e = '{z0: 63'd5, z1: 63'd0, z2: 63'd5};
        send(64'h0000_0003_0000_0003, 64'h0000_0003_0000_0003, 1'b1, e);
        e = '{z0: 63'h4000_0000_0000_0000, z1: 63'd0, z2: 63'h4000_0000_0000_0000};
        send(64'h8000_0000_8000_0000, 64'h8000_0000_8000_0000, 1'b1, e);

        // Downstream stall with an ignored in_valid pulse.
        e = '{z0: 63'h0000_0000_FFFF_FFFF, z1: 63'd0, z2: 63'h0000_0000_FFFF_FFFF};
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0001_0000_0001, 1'b1, e);
        rdy_mode = 2;
        w = 0;
        while (dut_if.out_valid !== 1'b1 && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 100) chk("stall_valid_timeout", 64'd1, 64'd0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                dut_if.a        = 64'hDEAD_BEEF_CAFE_F00D;
                dut_if.b        = 64'h1357_9BDF_2468_ACE0;
                dut_if.in_valid = 1'b1;
            end
            if (i == 5) dut_if.in_valid = 1'b0;
            chk("stall_valid", {63'd0, dut_if.out_valid}, 64'd1);
            chk("stall_in_ready", {63'd0, dut_if.in_ready}, 64'd0);
            chk("stall_z0", {1'b0, dut_if.z0}, 64'h0000_0000_FFFF_FFFF);
            chk("stall_z2", {1'b0, dut_if.z2}, 64'h0000_0000_FFFF_FFFF);
            chk("stall_z1", {1'b0, dut_if.z1}, 64'd0);
            @(posedge clk); #1;
        end
        rdy_mode = 0;
        w = 0;
        while (dut_if.out_valid === 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (w >= 20) chk("stall_release_timeout", 64'd1, 64'd0);
        chk("post_hs_in_ready", {63'd0, dut_if.in_ready}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("pulse_ignored_busy", {63'd0, dut_if.busy}, 64'd0);
        chk("pulse_ignored_valid", {63'd0, dut_if.out_valid}, 64'd0);

        // Abort an operation with reset at its 12th cycle.
        send(64'h0F0F_0F0F_F0F0_F0F0, 64'h3333_3333_5555_5555, 1'b0, e);
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("abort_out_valid", {63'd0, dut_if.out_valid}, 64'd0);
            chk("abort_z0", {1'b0, dut_if.z0}, 64'd0);
            chk("abort_z1", {1'b0, dut_if.z1}, 64'd0);
            chk("abort_z2", {1'b0, dut_if.z2}, 64'd0);
            chk("abort_busy", {63'd0, dut_if.busy}, 64'd0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1,
             golden(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321));

        // Random back-to-back traffic under random backpressure.
        rdy_mode = 1;
        for (int n = 0; n < 1000; n++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            send(ra, rb, 1'b1, golden(ra, rb));
        end

        rdy_mode = 0;
        w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            @(posedge clk); #1;
            w++;
        end
        chk("drain_remaining", 64'(exp_q.size()), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("txn_count", 64'(n_out), 64'(n_pushed));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
